lcd_msg_ctrl: RTL and testbench

Parametrised HD44780-compatible character LCD controller for the Spartan-3AN starter kit's 8-bit LCD interface. It runs the full power-up initialisation sequence, then keeps refreshing the display from an internal LINES×COLS character buffer. User logic writes the buffer through a single-cycle write port at any time. All LCD timing is expressed as clock-cycle counts, so the block is reusable at other clock rates and can be shortened for simulation.

---
 rtl/lcd_msg_ctrl.sv | 169 ++++++++++++++++
 tb/tb_lcd_msg_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_msg_ctrl.sv
// HD44780 8-bit character LCD controller: power-up init, then endless refresh of a
// LINES x COLS character buffer that user logic writes through a single-cycle port.
module lcd_msg_ctrl #(
    parameter int POWERUP_WAIT = 750000,
    parameter int INIT_WAIT_1  = 205000,
    parameter int INIT_WAIT_2  = 5000,
    parameter int E_PULSE      = 12,
    parameter int CMD_WAIT     = 2000,
    parameter int CLEAR_WAIT   = 82000,
    parameter int COLS         = 16,
    parameter int LINES        = 2,
    parameter int ADDR_W       = 5
) (
    input  logic              CLK_50MHZ,
    input  logic              BTN_SOUTH,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              init_done,
    output logic              frame_done,
    output logic [7:0]        LCD_DB,
    output logic              LCD_E,
    output logic              LCD_RS,
    output logic              LCD_RW,
    output logic [7:0]        LED
);
    localparam int unsigned NCHR     = LINES * COLS;
    localparam int          BUF_N    = 2 ** ADDR_W;
    localparam logic [3:0]  STEP_RUN = 4'd8;

    typedef enum logic [1:0] {S_PWR, S_SETUP, S_PULSE, S_HOLD} state_t;

    state_t            r_state, w_state_n;
    logic [31:0]       r_cnt, w_cnt_n, w_hold;
    logic [3:0]        r_step, w_step_n;
    logic              r_line, w_line_n;
    logic [5:0]        r_col, w_col_n;
    logic [ADDR_W-1:0] r_idx, w_idx_n;
    logic              r_init_done, w_init_n, w_frame_n;
    logic              r_frame_done, r_run, r_e, r_rs;
    logic [7:0]        r_db, w_fwd;
    logic [7:0]        r_buf [BUF_N];
    logic              w_data, w_cap, w_setup_n, w_data_n;

    function automatic logic [7:0] f_cmd(input logic [3:0] step, input logic line);
        case (step)
            4'd5:    return 8'h06;
            4'd6:    return 8'h0C;
            4'd7:    return 8'h01;
            4'd8:    return line ? 8'hC0 : 8'h80;
            default: return 8'h38;
        endcase
    endfunction

    always_ff @(posedge CLK_50MHZ or posedge BTN_SOUTH) begin
        if (BTN_SOUTH) begin
            for (int i = 0; i < BUF_N; i++) r_buf[i] <= 8'h20;
        end else if (wr_en && 32'(wr_addr) < NCHR) begin
            r_buf[wr_addr] <= wr_data;
        end
    end

    // Data byte is latched on its first SETUP cycle; a same-cycle write wins.
    assign w_data = (r_step == STEP_RUN) && (r_col != 6'd0);
    assign w_cap  = (r_state == S_SETUP) && (r_cnt == 32'd0) && w_data;
    assign w_fwd  = (wr_en && wr_addr == r_idx) ? wr_data : r_buf[r_idx];

    always_comb begin
        w_hold = 32'(CMD_WAIT);
        case (r_step)
            4'd1:    w_hold = 32'(INIT_WAIT_1);
            4'd2:    w_hold = 32'(INIT_WAIT_2);
            4'd7:    w_hold = 32'(CLEAR_WAIT);
            default: w_hold = 32'(CMD_WAIT);
        endcase
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt + 32'd1;
        w_step_n  = r_step;
        w_line_n  = r_line;
        w_col_n   = r_col;
        w_idx_n   = r_idx;
        w_init_n  = r_init_done;
        w_frame_n = 1'b0;
        case (r_state)
            S_PWR: if (r_cnt == 32'(POWERUP_WAIT - 1)) begin
                w_state_n = S_SETUP;
                w_cnt_n   = 32'd0;
                w_step_n  = 4'd1;
            end
            S_SETUP: begin
                if (w_cap) w_idx_n = r_idx + 1'b1;
                if (r_cnt == 32'd1) begin
                    w_state_n = S_PULSE;
                    w_cnt_n   = 32'd0;
                end
            end
            S_PULSE: if (r_cnt == 32'(E_PULSE - 1)) begin
                w_state_n = S_HOLD;
                w_cnt_n   = 32'd0;
            end
            default: if (r_cnt == w_hold - 32'd1) begin
                w_state_n = S_SETUP;
                w_cnt_n   = 32'd0;
                if (r_step != STEP_RUN) begin
                    w_step_n = r_step + 4'd1;
                    if (r_step == 4'd7) w_init_n = 1'b1;
                end else if (r_col == 6'(COLS)) begin
                    w_col_n = 6'd0;
                    if (r_line == 1'(LINES - 1)) begin
                        w_line_n  = 1'b0;
                        w_idx_n   = '0;
                        w_frame_n = 1'b1;
                    end else begin
                        w_line_n = r_line + 1'b1;
                    end
                end else begin
                    w_col_n = r_col + 6'd1;
                end
            end
        endcase
    end

    assign w_setup_n = (w_state_n == S_SETUP) && (r_state != S_SETUP);
    assign w_data_n  = (w_step_n == STEP_RUN) && (w_col_n != 6'd0);

    always_ff @(posedge CLK_50MHZ or posedge BTN_SOUTH) begin
        if (BTN_SOUTH) begin
            r_state      <= S_PWR;
            r_cnt        <= 32'd0;
            r_step       <= 4'd0;
            r_line       <= 1'b0;
            r_col        <= 6'd0;
            r_idx        <= '0;
            r_init_done  <= 1'b0;
            r_frame_done <= 1'b0;
            r_run        <= 1'b0;
            r_e          <= 1'b0;
            r_rs         <= 1'b0;
            r_db         <= 8'h00;
        end else begin
            r_state      <= w_state_n;
            r_cnt        <= w_cnt_n;
            r_step       <= w_step_n;
            r_line       <= w_line_n;
            r_col        <= w_col_n;
            r_idx        <= w_idx_n;
            r_init_done  <= w_init_n;
            r_frame_done <= w_frame_n;
            r_run        <= 1'b1;
            r_e          <= (w_state_n == S_PULSE);
            r_rs         <= w_data_n;
            if (w_cap)
                r_db <= w_fwd;
            else if (w_setup_n && !w_data_n)
                r_db <= f_cmd(w_step_n, w_line_n);
        end
    end

    assign LCD_DB     = w_cap ? w_fwd : r_db;
    assign LCD_E      = r_e;
    assign LCD_RS     = r_rs;
    assign LCD_RW     = 1'b0;
    assign init_done  = r_init_done;
    assign frame_done = r_frame_done;
    assign LED        = r_run ? {r_init_done, 7'(r_step) + 7'(r_line)} : 8'hFF;
endmodule

// File: tb/tb_lcd_msg_ctrl.sv
// Bench for lcd_msg_ctrl: random buffer writes checked cycle-by-cycle against a
// schedule/write-history model, plus a LINES=1 instance checked on pass spacing.
module tb_lcd_msg_ctrl;
    localparam int PW = 20, IW1 = 10, IW2 = 8, EP = 3, CW = 5, CLR = 7;
    localparam int COLS = 15, LINES = 2, AW = 5;
    localparam int NCHR = LINES * COLS, PASS = LINES * (COLS + 1);

    logic          clk = 1'b0, rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = 8'h00;
    logic          init_done, frame_done, LCD_E, LCD_RS, LCD_RW;
    logic [7:0]    LCD_DB, LED;

    logic          b_wr_en = 1'b0;
    logic [2:0]    b_wr_addr = 3'd0;
    logic [7:0]    b_wr_data = 8'h00;
    logic          b_init, b_frame, b_E, b_RS, b_RW;
    logic [7:0]    b_DB, b_LED;

    lcd_msg_ctrl #(.POWERUP_WAIT(PW), .INIT_WAIT_1(IW1), .INIT_WAIT_2(IW2), .E_PULSE(EP),
                   .CMD_WAIT(CW), .CLEAR_WAIT(CLR), .COLS(COLS), .LINES(LINES), .ADDR_W(AW))
    dut (.CLK_50MHZ(clk), .BTN_SOUTH(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
         .init_done(init_done), .frame_done(frame_done), .LCD_DB(LCD_DB), .LCD_E(LCD_E),
         .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LED(LED));

    lcd_msg_ctrl #(.POWERUP_WAIT(PW), .INIT_WAIT_1(IW1), .INIT_WAIT_2(IW2), .E_PULSE(EP),
                   .CMD_WAIT(CW), .CLEAR_WAIT(CLR), .COLS(8), .LINES(1), .ADDR_W(3))
    dut_b (.CLK_50MHZ(clk), .BTN_SOUTH(rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
           .wr_data(b_wr_data), .init_done(b_init), .frame_done(b_frame), .LCD_DB(b_DB),
           .LCD_E(b_E), .LCD_RS(b_RS), .LCD_RW(b_RW), .LED(b_LED));

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int tcyc = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, tcyc);
        end
    endtask

    always @(posedge clk) begin
        if (rst) tcyc = 0;
        else     tcyc = tcyc + 1;
    end

    // Model: transaction j starts at t_start; j<0 is the power-up wait.
    typedef struct {int cyc; int addr; int data;} wr_t;
    wr_t hist[$];
    int j, t_start, t_next;

    function automatic int buf_at(input int addr, input int c);
        for (int i = hist.size() - 1; i >= 0; i--)
            if (hist[i].cyc <= c && hist[i].addr == addr) return hist[i].data;
        return 'h20;
    endfunction

    function automatic int tx_hold(input int jj);
        case (jj)
            0:       return IW1;
            1:       return IW2;
            6:       return CLR;
            default: return CW;
        endcase
    endfunction

    function automatic int tx_line(input int jj);
        return (jj < 7) ? 0 : ((jj - 7) % PASS) / (COLS + 1);
    endfunction

    function automatic int tx_col(input int jj);
        return (jj < 7) ? 0 : ((jj - 7) % PASS) % (COLS + 1);
    endfunction

    function automatic int tx_idx(input int jj);
        return tx_line(jj) * COLS + tx_col(jj) - 1;
    endfunction

    function automatic int tx_db(input int jj, input int ts);
        if (jj < 7) begin
            case (jj)
                4:       return 'h06;
                5:       return 'h0C;
                6:       return 'h01;
                default: return 'h38;
            endcase
        end
        if (tx_col(jj) == 0) return (tx_line(jj) != 0) ? 'hC0 : 'h80;
        return buf_at(tx_idx(jj), ts);
    endfunction

    task automatic model_reset();
        j = -1; t_start = 0; t_next = PW;
        hist.delete();
    endtask

    task automatic model_cycle();
        int led_exp;
        if (tcyc == t_next) begin
            j++;
            t_start = t_next;
            t_next  = t_start + 2 + EP + tx_hold(j);
        end
        chk("lcd_e", 32'(LCD_E), 32'(j >= 0 && tcyc >= t_start + 2 && tcyc < t_start + 2 + EP));
        if (j < 0) begin
            chk("db_pwr", 32'(LCD_DB), 32'd0);
            chk("rs_pwr", 32'(LCD_RS), 32'd0);
        end else if (tcyc > t_start) begin
            chk("db", 32'(LCD_DB), 32'(tx_db(j, t_start)));
            chk("rs", 32'(LCD_RS), 32'(j >= 7 && tx_col(j) != 0));
        end
        chk("init_done", 32'(init_done), 32'(j >= 7));
        chk("frame_done", 32'(frame_done), 32'(j > 7 && (j - 7) % PASS == 0 && tcyc == t_start));
        if (tcyc == 0) led_exp = 'hFF;
        else led_exp = ((j >= 7) ? 128 : 0) + ((j < 0) ? 0 : (j < 7) ? j + 1 : 8 + tx_line(j));
        chk("led", 32'(LED), 32'(led_exp));
        chk("rw", 32'(LCD_RW), 32'd0);
    endtask

    task automatic do_wr(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = 8'(d);
        if (a < NCHR) hist.push_back('{tcyc, a, d});
    endtask

    task automatic drive_rand();
        int r;
        r = $urandom_range(0, 9);
        if (j >= 7 && tx_col(j) != 0 && (tcyc == t_start || tcyc == t_start + 1) && r < 5)
            do_wr(tx_idx(j), $urandom_range(0, 255));
        else if (r < 6)
            do_wr($urandom_range(0, 31), $urandom_range(0, 255));
    endtask

    // LINES=1 instance: one 0x80 command and 8 data bytes per pass.
    int b_last = -1, b_cnt = 0, b_cmd = 0;
    logic b_eprev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            b_last = -1; b_cnt = 0; b_cmd = 0; b_eprev = 1'b0;
        end else begin
            if (b_E && !b_eprev) begin
                b_cnt++;
                if (!b_RS) b_cmd++;
                if (b_init && !b_RS) chk("b_cmd_db", 32'(b_DB), 32'h80);
            end
            if (b_frame) begin
                if (b_last >= 0) begin
                    chk("b_gap", 32'(tcyc - b_last), 32'(9 * (2 + EP + CW)));
                    chk("b_tx", 32'(b_cnt), 32'd9);
                    chk("b_ncmd", 32'(b_cmd), 32'd1);
                end
                b_last = tcyc; b_cnt = 0; b_cmd = 0;
            end
            b_eprev = b_E;
        end
    end

    initial begin
        bit found;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_db", 32'(LCD_DB), 32'd0);
        chk("rst_e", 32'(LCD_E), 32'd0);
        chk("rst_rs", 32'(LCD_RS), 32'd0);
        chk("rst_init", 32'(init_done), 32'd0);
        chk("rst_frame", 32'(frame_done), 32'd0);
        chk("rst_led", 32'(LED), 32'hFF);

        // Directed writes during init, then two clean passes.
        rst = 1'b0;
        for (int c = 0; c < 800; c++) begin
            model_cycle();
            wr_en = 1'b0;
            if (tcyc == 5) do_wr(0, 'h44);
            if (tcyc == 6) do_wr(17, 'h41);
            if (tcyc == 7) do_wr(31, 'h55);
            if (tcyc == 8) do_wr(30, 'h56);
            @(negedge clk);
        end

        for (int c = 0; c < 1500; c++) begin
            model_cycle();
            wr_en = 1'b0;
            drive_rand();
            @(negedge clk);
        end

        wr_en = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            model_cycle();
            if (LCD_E === 1'b1 && j >= 7) found = 1'b1;
            else @(negedge clk);
        end
        chk("mid_rst_wait", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_e", 32'(LCD_E), 32'd0);
        chk("mid_rst_led", 32'(LED), 32'hFF);
        chk("mid_rst_b_e", 32'(b_E), 32'd0);
        model_reset();
        repeat (3) @(negedge clk);

        rst = 1'b0;
        for (int c = 0; c < 900; c++) begin
            model_cycle();
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
